// File: rtl/adder_tree_pkg.sv
// -----------------------------------------------------------------------------
// adder_tree_pkg
// Shared elaboration helpers for the pipelined adder-tree accumulator:
//   num_inputs(n, stage)          element count entering tree layer `stage`
//   layer_registered(i, l, stride) whether tree layer i ends in a register
//   pipe_latency(n, stride)       cycles from beat acceptance to o_valid
//   sat_narrow(v, out_w)          clamp a signed value to a signed out_w range
// -----------------------------------------------------------------------------
package adder_tree_pkg;

    // Each layer pairs its inputs, so the count halves rounding up.
    function automatic int num_inputs(input int n, input int stage);
        int c;
        c = n;
        for (int s = 0; s < stage; s++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    // The final layer is always registered so the accumulator sees a clean
    // register-to-register path regardless of the stride.
    function automatic bit layer_registered(input int i, input int l, input int stride);
        return ((i % stride) == (stride - 1)) || (i == (l - 1));
    endfunction

    // Registered tree layers plus the accumulator/output register.
    function automatic int pipe_latency(input int n, input int stride);
        int r;
        int l;
        r = 0;
        l = $clog2(n);
        for (int i = 0; i < l; i++) begin
            if (layer_registered(i, l, stride)) begin
                r++;
            end
        end
        return r + 1;
    endfunction

    // Works on a 64-bit signed carrier; callers sign-extend into it and
    // truncate the clamped value back to out_w bits.
    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                      input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/adder_tree_layer.sv
// -----------------------------------------------------------------------------
// adder_tree_layer
// One reduction layer of the signed adder tree. Adjacent element pairs are
// summed into elements one bit wider; an odd leftover element is sign-extended
// and passed through. With REG=1 the outputs are registered (enable-gated),
// otherwise the layer is purely combinational.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (valid/last only)
//   en              global pipeline advance
//   in_data         IN_COUNT packed signed elements of IN_WIDTH bits
//   in_valid/last   beat qualifiers travelling with the data
//   out_data        ceil(IN_COUNT/2) packed signed elements of IN_WIDTH+1 bits
//   out_valid/last  qualifiers aligned with out_data
// -----------------------------------------------------------------------------
module adder_tree_layer #(
    parameter int IN_COUNT = 2,
    parameter int IN_WIDTH = 16,
    parameter bit REG      = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    en,
    input  logic [IN_COUNT*IN_WIDTH-1:0]            in_data,
    input  logic                                    in_valid,
    input  logic                                    in_last,
    output logic [((IN_COUNT+1)/2)*(IN_WIDTH+1)-1:0] out_data,
    output logic                                    out_valid,
    output logic                                    out_last
);

    localparam int OUT_COUNT = (IN_COUNT + 1) / 2;
    localparam int OUT_W     = IN_WIDTH + 1;

    logic [OUT_COUNT*OUT_W-1:0] sum;

    for (genvar k = 0; k < OUT_COUNT; k++) begin : g_pair
        logic signed [IN_WIDTH-1:0] a;
        assign a = in_data[2*k*IN_WIDTH +: IN_WIDTH];

        if (2*k + 1 < IN_COUNT) begin : g_add
            logic signed [IN_WIDTH-1:0] b;
            assign b = in_data[(2*k+1)*IN_WIDTH +: IN_WIDTH];
            assign sum[k*OUT_W +: OUT_W] = OUT_W'(a) + OUT_W'(b);
        end else begin : g_pass
            assign sum[k*OUT_W +: OUT_W] = OUT_W'(a);
        end
    end

    if (REG) begin : g_reg
        logic [OUT_COUNT*OUT_W-1:0] data_q;
        logic                       valid_q;
        logic                       last_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else if (en) begin
                valid_q <= in_valid;
                last_q  <= in_last;
            end
        end

        // NOTE: data registers carry no reset; valid_q qualifies them, and
        // leaving the wide datapath unreset keeps the reset fan-out small.
        always_ff @(posedge clk) begin
            if (en) begin
                data_q <= sum;
            end
        end

        assign out_data  = data_q;
        assign out_valid = valid_q;
        assign out_last  = last_q;
    end else begin : g_comb
        // Clock/reset/enable have no loads in a combinational layer.
        logic unused_ctrl;
        assign unused_ctrl = &{1'b0, clk, rst, en};

        assign out_data  = sum;
        assign out_valid = in_valid;
        assign out_last  = in_last;
    end

endmodule

// File: rtl/adder_tree_acc.sv
// -----------------------------------------------------------------------------
// adder_tree_acc
// Pipelined signed multi-beat reduction. Each accepted beat of NUM_INPUTS
// elements is summed by a clog2(NUM_INPUTS)-layer adder tree; tree sums are
// accumulated until a beat tagged i_last, which produces one result together
// with the number of beats in the group. Full valid/ready backpressure: a
// result held by o_ready low freezes the entire pipe.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_data            NUM_INPUTS packed signed elements, element j at
//                     [j*DATA_WIDTH +: DATA_WIDTH]
//   i_last            beat closes the current accumulation group
//   i_valid, i_ready  input handshake (i_ready is combinational)
//   o_data            signed group result, OUT_WIDTH bits
//   o_beats           beats in the group, saturating at 2^BEAT_WIDTH-1
//   o_valid, o_ready  output handshake
//
// Build option:
//   ADDER_TREE_ACC_SAT_EN  defined: o_data saturates to the signed OUT_WIDTH
//                          range; undefined: o_data is the low OUT_WIDTH bits.
//
// Parameter constraints: NUM_INPUTS >= 1, PIPE_STRIDE >= 1,
// DATA_WIDTH + clog2(NUM_INPUTS) <= ACC_WIDTH <= 64, OUT_WIDTH <= ACC_WIDTH.
// -----------------------------------------------------------------------------
module adder_tree_acc
    import adder_tree_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_INPUTS  = 27,
    parameter int PIPE_STRIDE = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 24,
    parameter int BEAT_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH*NUM_INPUTS-1:0]   i_data,
    input  logic                               i_last,
    input  logic                               i_valid,
    output logic                               i_ready,
    output logic signed [OUT_WIDTH-1:0]        o_data,
    output logic [BEAT_WIDTH-1:0]              o_beats,
    output logic                               o_valid,
    input  logic                               o_ready
);

    localparam int L         = $clog2(NUM_INPUTS);
    localparam int SUM_WIDTH = DATA_WIDTH + L;

    // Global advance: everything moves unless a result is waiting unconsumed.
    logic en;
    assign en      = ~(o_valid & ~o_ready);
    assign i_ready = en;

    logic signed [SUM_WIDTH-1:0] tree_sum;
    logic                        tree_valid;
    logic                        tree_last;

    if (L == 0) begin : g_wire
        assign tree_sum   = i_data;
        assign tree_valid = i_valid;
        assign tree_last  = i_last;
    end else begin : g_tree
        for (genvar i = 0; i < L; i++) begin : g_layer
            localparam int IN_CNT  = num_inputs(NUM_INPUTS, i);
            localparam int OUT_CNT = num_inputs(NUM_INPUTS, i + 1);
            localparam int IN_W    = DATA_WIDTH + i;

            logic [IN_CNT*IN_W-1:0]       in_data;
            logic                         in_valid;
            logic                         in_last;
            logic [OUT_CNT*(IN_W+1)-1:0]  out_data;
            logic                         out_valid;
            logic                         out_last;

            if (i == 0) begin : g_first
                assign in_data  = i_data;
                assign in_valid = i_valid;
                assign in_last  = i_last;
            end else begin : g_next
                assign in_data  = g_layer[i-1].out_data;
                assign in_valid = g_layer[i-1].out_valid;
                assign in_last  = g_layer[i-1].out_last;
            end

            adder_tree_layer #(
                .IN_COUNT (IN_CNT),
                .IN_WIDTH (IN_W),
                .REG      (layer_registered(i, L, PIPE_STRIDE))
            ) u_layer (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .in_data   (in_data),
                .in_valid  (in_valid),
                .in_last   (in_last),
                .out_data  (out_data),
                .out_valid (out_valid),
                .out_last  (out_last)
            );
        end

        assign tree_sum   = g_layer[L-1].out_data;
        assign tree_valid = g_layer[L-1].out_valid;
        assign tree_last  = g_layer[L-1].out_last;
    end

    // ------------------------------------------------------------------
    // Accumulator and output stage
    // ------------------------------------------------------------------
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic [BEAT_WIDTH-1:0]       beats;
    logic [BEAT_WIDTH-1:0]       beats_next;
    logic signed [OUT_WIDTH-1:0] result;

    // Sign-extended tree sum; the add wraps modulo 2^ACC_WIDTH.
    assign acc_next   = acc + ACC_WIDTH'(tree_sum);
    assign beats_next = (&beats) ? beats : beats + BEAT_WIDTH'(1);

`ifdef ADDER_TREE_ACC_SAT_EN
    assign result = OUT_WIDTH'(sat_narrow(64'(acc_next), OUT_WIDTH));
`else
    assign result = OUT_WIDTH'(acc_next);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            beats   <= '0;
            o_data  <= '0;
            o_beats <= '0;
            o_valid <= 1'b0;
        end else if (en) begin
            // A completing group overrides this default below; a consumed
            // result and a new one on the same edge therefore go back-to-back.
            o_valid <= 1'b0;
            if (tree_valid) begin
                if (tree_last) begin
                    o_data  <= result;
                    o_beats <= beats_next;
                    o_valid <= 1'b1;
                    acc     <= '0;
                    beats   <= '0;
                end else begin
                    acc     <= acc_next;
                    beats   <= beats_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// -----------------------------------------------------------------------------
// tb_adder_tree_acc
// Directed self-checking bench for adder_tree_acc. Main instance uses the
// default configuration (27 inputs, stride 2); two small instances cover the
// wire-only tree (1 input) and a fully registered tree (5 inputs, stride 1).
// -----------------------------------------------------------------------------
module tb_adder_tree_acc;
    import adder_tree_pkg::*;

    localparam int DW = 16;
    localparam int N  = 27;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Main instance
    logic [DW*N-1:0]    i_data;
    logic               i_last;
    logic               i_valid;
    logic               i_ready;
    logic signed [23:0] o_data;
    logic [7:0]         o_beats;
    logic               o_valid;
    logic               o_ready;

    adder_tree_acc #(
        .DATA_WIDTH (16),
        .NUM_INPUTS (27),
        .PIPE_STRIDE(2),
        .ACC_WIDTH  (32),
        .OUT_WIDTH  (24),
        .BEAT_WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_last  (i_last),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_beats (o_beats),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    // Single-input instance: the tree is a wire
    logic [15:0]        a_data;
    logic               a_last;
    logic               a_valid;
    logic               a_iready;
    logic signed [23:0] a_odata;
    logic [7:0]         a_obeats;
    logic               a_ovalid;
    logic               a_oready;

    adder_tree_acc #(
        .NUM_INPUTS (1),
        .PIPE_STRIDE(2)
    ) dut_n1 (
        .clk     (clk),
        .rst     (rst),
        .i_data  (a_data),
        .i_last  (a_last),
        .i_valid (a_valid),
        .i_ready (a_iready),
        .o_data  (a_odata),
        .o_beats (a_obeats),
        .o_valid (a_ovalid),
        .o_ready (a_oready)
    );

    // Five-input instance, every layer registered
    logic [79:0]        b_data;
    logic               b_last;
    logic               b_valid;
    logic               b_iready;
    logic signed [23:0] b_odata;
    logic [7:0]         b_obeats;
    logic               b_ovalid;
    logic               b_oready;

    adder_tree_acc #(
        .NUM_INPUTS (5),
        .PIPE_STRIDE(1)
    ) dut_n5 (
        .clk     (clk),
        .rst     (rst),
        .i_data  (b_data),
        .i_last  (b_last),
        .i_valid (b_valid),
        .i_ready (b_iready),
        .o_data  (b_odata),
        .o_beats (b_obeats),
        .o_valid (b_ovalid),
        .o_ready (b_oready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*N-1:0] fill(input logic signed [15:0] v);
        return {N{v}};
    endfunction

    // Results handed over on the main instance, captured mid-cycle
    typedef struct {
        logic signed [23:0] data;
        logic [7:0]         beats;
    } res_t;

    res_t results[$];

    always @(negedge clk) begin
        if (!rst && o_valid && o_ready) begin
            results.push_back('{o_data, o_beats});
        end
    end

    // Call after the acceptance edge of the last beat; returns edges counted
    // from (and including) that edge until o_valid is seen.
    task automatic wait_result(output int lat);
        lat = 1;
        while (!o_valid && lat < 8 * pipe_latency(27, 2)) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int sent;
    int stall;
    bit prev_hold;
    logic signed [23:0] held_data;

    initial begin
        rst      = 1'b1;
        i_data   = '0;
        i_last   = 1'b0;
        i_valid  = 1'b0;
        o_ready  = 1'b1;
        a_data   = '0;
        a_last   = 1'b0;
        a_valid  = 1'b0;
        a_oready = 1'b1;
        b_data   = '0;
        b_last   = 1'b0;
        b_valid  = 1'b0;
        b_oready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // ---------------- reset state ----------------
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_beats", o_beats, 0);
        check("rst_i_ready", i_ready, 1);
        check("rst_n1_o_valid", a_ovalid, 0);
        check("rst_n5_o_valid", b_ovalid, 0);

        // ---------------- single beat of ones ----------------
        i_data  = fill(16'sd1);
        i_last  = 1'b1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        wait_result(lat);
        check("ones_latency", lat, 4);
        check("ones_data", o_data, 27);
        check("ones_beats", o_beats, 1);
        tick();
        check("ones_pulse_end", o_valid, 0);

        // ---------------- three beats of -2 ----------------
        results.delete();
        i_data  = fill(-16'sd2);
        i_valid = 1'b1;
        i_last  = 1'b0;
        tick();
        tick();
        i_last = 1'b1;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        wait_result(lat);
        check("neg_latency", lat, 4);
        check("neg_data", o_data, -162);
        check("neg_beats", o_beats, 3);
        repeat (6) tick();
        check("neg_one_pulse", results.size(), 1);

        // ---------------- 8 back-to-back groups with a 5-cycle stall ----------------
        results.delete();
        sent      = 0;
        stall     = 0;
        prev_hold = 1'b0;
        held_data = '0;
        for (int c = 0; c < 40; c++) begin
            o_ready = !(c >= 6 && c < 11);
            i_valid = (sent < 8);
            i_data  = fill(16'(sent + 1));
            i_last  = 1'b1;
            #1;
            if (!i_ready) begin
                stall++;
            end
            if (prev_hold) begin
                check("stall_data_hold", o_data, held_data);
                check("stall_valid_hold", o_valid, 1);
            end
            prev_hold = o_valid && !o_ready;
            held_data = o_data;
            if (i_valid && i_ready) begin
                sent++;
            end
            tick();
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        o_ready = 1'b1;
        check("stall_cycles", stall, 5);
        check("stall_sent", sent, 8);
        check("stall_count", results.size(), 8);
        if (results.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("stall_res%0d_data", k), results[k].data, 27 * (k + 1));
                check($sformatf("stall_res%0d_beats", k), results[k].beats, 1);
            end
        end

        // ---------------- 300 beats of 32767 ----------------
        i_data  = fill(16'sd32767);
        i_valid = 1'b1;
        for (int b = 0; b < 300; b++) begin
            i_last = (b == 299);
            tick();
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        wait_result(lat);
        check("big_latency", lat, 4);
`ifdef ADDER_TREE_ACC_SAT_EN
        check("big_data_sat", o_data, 8388607);
`else
        // 300*27*32767 = 265412700; mod 2^24 = 13754460; as signed 24-bit
        check("big_data_wrap", o_data, -3022756);
`endif
        check("big_beats_sat", o_beats, 255);
        tick();

        // ---------------- reset mid-group ----------------
        i_data  = fill(16'sd5);
        i_valid = 1'b1;
        i_last  = 1'b0;
        tick();
        tick();
        i_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_o_valid", o_valid, 0);
        i_data  = fill(16'sd1);
        i_last  = 1'b1;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        i_last  = 1'b0;
        wait_result(lat);
        check("midrst_latency", lat, 4);
        check("midrst_data", o_data, 27);
        check("midrst_beats", o_beats, 1);
        tick();

        // ---------------- NUM_INPUTS = 1 ----------------
        a_data  = -16'sd7;
        a_last  = 1'b1;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        lat = 1;
        while (!a_ovalid && lat < 20) begin
            tick();
            lat++;
        end
        check("n1_latency", lat, 1);
        check("n1_data", a_odata, -7);
        check("n1_beats", a_obeats, 1);
        a_data  = 16'sd100;
        a_last  = 1'b0;
        a_valid = 1'b1;
        tick();
        a_data = -16'sd30;
        a_last = 1'b1;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
        lat = 1;
        while (!a_ovalid && lat < 20) begin
            tick();
            lat++;
        end
        check("n1_grp_latency", lat, 1);
        check("n1_grp_data", a_odata, 70);
        check("n1_grp_beats", a_obeats, 2);

        // ---------------- NUM_INPUTS = 5, PIPE_STRIDE = 1 ----------------
        b_data  = {-16'sd500, 16'sd4000, 16'sd3000, -16'sd2000, 16'sd1000};
        b_last  = 1'b1;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        b_last  = 1'b0;
        lat = 1;
        while (!b_ovalid && lat < 20) begin
            tick();
            lat++;
        end
        check("n5_latency", lat, 4);
        check("n5_data", b_odata, 5500);
        check("n5_beats", b_obeats, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
